note_sequencer: RTL and testbench

- Playback and record controller for the 12-entry x 4-bit note SRAM on the LaunchPad.
- Shares the single SRAM port between two users: keypad record writes and a timed playback engine.
- The playback engine steps through addresses 0..len-1 at a fixed tempo and drives the PianoPlay enable and note inputs.
- Sits between the 12-to-4 keypad encoder / record register path, SRAM12bits and PianoPlay.

---
 rtl/note_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_note_sequencer.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// -----------------------------------------------------------------------------
// note_sequencer
//
// Playback and record controller for the LaunchPad note SRAM (DEPTH x 4 bits).
// One SRAM port is shared between keypad record writes and a timed playback
// engine. The engine walks addresses 0..len_eff-1, reads each note code, and
// drives PianoPlay with the note for NOTE_CYCLES followed by silence for the
// rest of the step. Codes 12..15 are rests and keep note_en low.
//
// Ports:
//   CLK        system clock, rising edge
//   RST        asynchronous active-low reset
//   rec_req    record write request, held until rec_ack
//   rec_addr   record target address
//   rec_data   record note code
//   rec_ack    write granted this cycle (combinational)
//   play_start start / restart playback (level, sampled every cycle)
//   play_stop  abort playback, wins over play_start
//   loop_en    wrap to step 0 after the last step instead of finishing
//   len        number of steps, clamped to DEPTH and latched at start
//   mem_addr   SRAM address
//   mem_we     SRAM write enable
//   mem_wdata  SRAM write data
//   mem_rdata  SRAM read data, valid one cycle after the address
//   note_en    PianoPlay enable
//   note_bin   PianoPlay note code
//   busy       high whenever the engine is not idle
//   step_idx   current step number
//   done       one-cycle pulse at the natural end of playback
// -----------------------------------------------------------------------------
module note_sequencer #(
    parameter int DEPTH       = 12,
    parameter int STEP_CYCLES = 1000000,
    parameter int NOTE_CYCLES = 750000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       rec_req,
    input  logic [3:0] rec_addr,
    input  logic [3:0] rec_data,
    output logic       rec_ack,
    input  logic       play_start,
    input  logic       play_stop,
    input  logic       loop_en,
    input  logic [3:0] len,
    output logic [3:0] mem_addr,
    output logic       mem_we,
    output logic [3:0] mem_wdata,
    input  logic [3:0] mem_rdata,
    output logic       note_en,
    output logic [3:0] note_bin,
    output logic       busy,
    output logic [3:0] step_idx,
    output logic       done
);

    localparam int             TW        = $clog2(STEP_CYCLES);
    localparam logic [TW-1:0]  NOTE_LAST = TW'(NOTE_CYCLES - 1);
    localparam logic [TW-1:0]  STEP_LAST = TW'(STEP_CYCLES - 1);
    localparam logic [3:0]     DEPTH_L   = 4'(DEPTH);
    localparam logic [3:0]     REST_CODE = 4'd12;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT,
        PLAY,
        GAP
    } state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [3:0]    step_nxt;
    logic [3:0]    note_nxt;
    logic [3:0]    len_eff, len_nxt;
    logic          done_nxt;
    logic [3:0]    len_sat;
    logic          start_ok;
    logic          grant;

    // Oversized lengths are clamped to the SRAM depth; a zero length
    // request is treated as no request at all.
    assign len_sat  = (len > DEPTH_L) ? DEPTH_L : len;
    assign start_ok = play_start && (len != 4'd0);

    // Register bank: everything returns to idle the moment RST falls, so a
    // reset mid-note silences the piano without producing a done pulse.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            timer    <= '0;
            step_idx <= 4'd0;
            note_bin <= 4'd0;
            len_eff  <= 4'd0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            step_idx <= step_nxt;
            note_bin <= note_nxt;
            len_eff  <= len_nxt;
            done     <= done_nxt;
        end
    end

    // Next-state logic. The per-state sequencing is decided first, then a
    // restart and finally a stop override it, which gives stop priority
    // over start and start priority over the natural end of a step.
    // note_bin is captured from the read issued in RD, so a record write
    // landing in WAIT or later cannot disturb the note that is playing.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        step_nxt  = step_idx;
        note_nxt  = note_bin;
        len_nxt   = len_eff;
        done_nxt  = 1'b0;

        case (state)
            IDLE: begin
            end
            RD: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                note_nxt  = mem_rdata;
                timer_nxt = '0;
                state_nxt = PLAY;
            end
            PLAY: begin
                timer_nxt = timer + TW'(1);
                if (timer == NOTE_LAST) begin
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (timer == STEP_LAST) begin
                    timer_nxt = '0;
                    if (step_idx + 4'd1 < len_eff) begin
                        step_nxt  = step_idx + 4'd1;
                        state_nxt = RD;
                    end else if (loop_en) begin
                        step_nxt  = 4'd0;
                        state_nxt = RD;
                    end else begin
                        step_nxt  = 4'd0;
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (start_ok) begin
            state_nxt = RD;
            step_nxt  = 4'd0;
            timer_nxt = '0;
            len_nxt   = len_sat;
            done_nxt  = 1'b0;
        end

        if (play_stop) begin
            state_nxt = IDLE;
            step_nxt  = 4'd0;
            timer_nxt = '0;
            done_nxt  = 1'b0;
        end
    end

    // SRAM port sharing: the recorder owns the port in every cycle except
    // RD, where the playback read must go out. Out-of-range record
    // addresses are acknowledged so the requester is released, but the
    // write itself is suppressed. Nothing is granted while in reset.
    always_comb begin
        grant     = RST && rec_req && (state != RD);
        rec_ack   = grant;
        mem_we    = grant && (rec_addr < DEPTH_L);
        mem_addr  = grant ? rec_addr : step_idx;
        mem_wdata = grant ? rec_data : 4'd0;
    end

    // Player-facing status. The enable only sounds in PLAY and only for
    // real note codes; rest codes keep the step silent.
    always_comb begin
        note_en = (state == PLAY) && (note_bin < REST_CODE);
        busy    = (state != IDLE);
    end

endmodule

// File: tb/tb_note_sequencer.sv
// -----------------------------------------------------------------------------
// tb_note_sequencer
//
// Bench for note_sequencer with short step timing (STEP_CYCLES=8,
// NOTE_CYCLES=5). Holds a small SRAM model, a step/phase reference model of
// the playback engine and port arbitration, a vector table for the basic
// playback run, hand-written corner-case sequences and a random phase.
// -----------------------------------------------------------------------------
module tb_note_sequencer;

    localparam int STEP  = 8;
    localparam int NOTE  = 5;
    localparam int DEPTH = 12;

    logic       CLK        = 1'b0;
    logic       RST        = 1'b0;
    logic       rec_req    = 1'b0;
    logic [3:0] rec_addr   = 4'd0;
    logic [3:0] rec_data   = 4'd0;
    logic       play_start = 1'b0;
    logic       play_stop  = 1'b0;
    logic       loop_en    = 1'b0;
    logic [3:0] len        = 4'd0;
    logic [3:0] mem_rdata  = 4'd0;
    logic       rec_ack;
    logic [3:0] mem_addr;
    logic       mem_we;
    logic [3:0] mem_wdata;
    logic       note_en;
    logic [3:0] note_bin;
    logic       busy;
    logic [3:0] step_idx;
    logic       done;

    int total = 0;
    int bad   = 0;

    note_sequencer #(
        .DEPTH      (DEPTH),
        .STEP_CYCLES(STEP),
        .NOTE_CYCLES(NOTE)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .rec_req   (rec_req),
        .rec_addr  (rec_addr),
        .rec_data  (rec_data),
        .rec_ack   (rec_ack),
        .play_start(play_start),
        .play_stop (play_stop),
        .loop_en   (loop_en),
        .len       (len),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .note_en   (note_en),
        .note_bin  (note_bin),
        .busy      (busy),
        .step_idx  (step_idx),
        .done      (done)
    );

    always #5 CLK = ~CLK;

    // Synchronous-read SRAM: data for an address appears one cycle later.
    logic [3:0] sram [0:DEPTH-1];
    always @(posedge CLK) begin
        if (mem_we && mem_addr < 4'd12) sram[mem_addr] <= mem_wdata;
        mem_rdata <= (mem_addr < 4'd12) ? sram[mem_addr] : 4'd0;
    end

    // Reference model: a step runs through phases 0..STEP+1, where phase 0
    // is the read, phase 1 the wait, and phases 2..STEP+1 the timed part.
    bit m_active;
    bit m_done;
    int m_step;
    int m_phase;
    int m_len;
    int m_note;
    int m_snap;
    int gold [DEPTH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_done   = 1'b0;
        m_step   = 0;
        m_phase  = 0;
        m_len    = 0;
        m_note   = 0;
        m_snap   = 0;
    endtask

    function automatic bit exp_grant();
        return (RST && rec_req && !(m_active && m_phase == 0));
    endfunction

    task automatic model_update();
        bit g;
        if (!RST) begin
            model_reset();
            return;
        end
        g = exp_grant();
        if (m_active && m_phase == 0) m_snap = gold[m_step];
        if (m_active && m_phase == 1) m_note = m_snap;
        if (g && rec_addr < 4'd12) gold[rec_addr] = int'(rec_data);
        m_done = 1'b0;
        if (play_stop) begin
            m_active = 1'b0;
            m_step   = 0;
        end else if (play_start && len != 4'd0) begin
            m_active = 1'b1;
            m_step   = 0;
            m_phase  = 0;
            m_len    = (int'(len) > DEPTH) ? DEPTH : int'(len);
        end else if (m_active) begin
            if (m_phase == STEP + 1) begin
                m_phase = 0;
                if (m_step < m_len - 1) begin
                    m_step++;
                end else if (loop_en) begin
                    m_step = 0;
                end else begin
                    m_active = 1'b0;
                    m_step   = 0;
                    m_done   = 1'b1;
                end
            end else begin
                m_phase++;
            end
        end
    endtask

    task automatic checkOutput();
        bit g;
        bit w;
        int ea;
        g  = exp_grant();
        w  = g && (rec_addr < 4'd12);
        ea = g ? int'(rec_addr) : m_step;
        chk("busy",     32'(busy),     32'(m_active));
        chk("step_idx", 32'(step_idx), 32'(m_step));
        chk("note_en",  32'(note_en),
            32'(m_active && m_phase >= 2 && m_phase < 2 + NOTE && m_note < 12));
        chk("note_bin", 32'(note_bin), 32'(m_note));
        chk("done",     32'(done),     32'(m_done));
        chk("rec_ack",  32'(rec_ack),  32'(g));
        chk("mem_we",   32'(mem_we),   32'(w));
        chk("mem_addr", 32'(mem_addr), 32'(ea));
        if (w) chk("mem_wdata", 32'(mem_wdata), 32'(rec_data));
    endtask

    task automatic applyStimulus(input logic s, input logic p, input logic lp,
                                 input logic [3:0] l, input logic rq,
                                 input logic [3:0] ra, input logic [3:0] rd);
        play_start = s;
        play_stop  = p;
        loop_en    = lp;
        len        = l;
        rec_req    = rq;
        rec_addr   = ra;
        rec_data   = rd;
    endtask

    // One clock: model check, model advance, then on to the next negedge.
    task automatic advance_cycle();
        #1;
        checkOutput();
        model_update();
        @(negedge CLK);
    endtask

    typedef struct {
        int         hold;
        logic       start;
        logic       exp_busy;
        logic       exp_en;
        logic [3:0] exp_note;
        logic [3:0] exp_step;
        logic       exp_done;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int dones;
        int n;
        int max_step;
        bit hit;

        for (int i = 0; i < DEPTH; i++) gold[i] = 0;
        model_reset();

        // Basic playback of 3,7,12 with len=3: one start cycle, RD/WAIT,
        // 5 sounding cycles, 3 gap cycles per step, rest step silent.
        vecs.push_back('{1, 1'b1, 1'b0, 1'b0, 4'd0,  4'd0, 1'b0});
        vecs.push_back('{2, 1'b0, 1'b1, 1'b0, 4'd0,  4'd0, 1'b0});
        vecs.push_back('{5, 1'b0, 1'b1, 1'b1, 4'd3,  4'd0, 1'b0});
        vecs.push_back('{3, 1'b0, 1'b1, 1'b0, 4'd3,  4'd0, 1'b0});
        vecs.push_back('{2, 1'b0, 1'b1, 1'b0, 4'd3,  4'd1, 1'b0});
        vecs.push_back('{5, 1'b0, 1'b1, 1'b1, 4'd7,  4'd1, 1'b0});
        vecs.push_back('{3, 1'b0, 1'b1, 1'b0, 4'd7,  4'd1, 1'b0});
        vecs.push_back('{2, 1'b0, 1'b1, 1'b0, 4'd7,  4'd2, 1'b0});
        vecs.push_back('{8, 1'b0, 1'b1, 1'b0, 4'd12, 4'd2, 1'b0});
        vecs.push_back('{1, 1'b0, 1'b0, 1'b0, 4'd12, 4'd0, 1'b1});
        vecs.push_back('{2, 1'b0, 1'b0, 1'b0, 4'd12, 4'd0, 1'b0});

        // Reset state, with a record request that must not be granted.
        @(negedge CLK);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd1, 4'd1);
        #1;
        chk("rst_rec_ack",  32'(rec_ack),  32'd0);
        chk("rst_mem_we",   32'(mem_we),   32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_note_en",  32'(note_en),  32'd0);
        chk("rst_step_idx", 32'(step_idx), 32'd0);
        chk("rst_note_bin", 32'(note_bin), 32'd0);
        chk("rst_done",     32'(done),     32'd0);
        advance_cycle();
        RST = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0);
        advance_cycle();

        // Preload the SRAM through the record path.
        for (int a = 0; a < DEPTH; a++) begin
            logic [3:0] d;
            d = 4'((a * 5 + 3) % 16);
            if (a == 0) d = 4'd3;
            if (a == 1) d = 4'd7;
            if (a == 2) d = 4'd12;
            applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 4'(a), d);
            advance_cycle();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd13, 4'd9);
        #1;
        chk("oob_rec_ack", 32'(rec_ack), 32'd1);
        chk("oob_mem_we",  32'(mem_we),  32'd0);
        advance_cycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0);
        advance_cycle();

        // Table-driven basic playback.
        foreach (vecs[k]) begin
            for (int c = 0; c < vecs[k].hold; c++) begin
                applyStimulus(vecs[k].start, 1'b0, 1'b0, 4'd3, 1'b0, 4'd0, 4'd0);
                #1;
                chk($sformatf("vec%0d_busy", k),    32'(busy),     32'(vecs[k].exp_busy));
                chk($sformatf("vec%0d_note_en", k), 32'(note_en),  32'(vecs[k].exp_en));
                chk($sformatf("vec%0d_note", k),    32'(note_bin), 32'(vecs[k].exp_note));
                chk($sformatf("vec%0d_step", k),    32'(step_idx), 32'(vecs[k].exp_step));
                chk($sformatf("vec%0d_done", k),    32'(done),     32'(vecs[k].exp_done));
                advance_cycle();
            end
        end

        // Looping over two steps: 0,1,0,1 and no done, then stop.
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd2, 1'b0, 4'd0, 4'd0);
        advance_cycle();
        play_start = 1'b0;
        dones = 0;
        for (int c = 1; c <= 40; c++) begin
            #1;
            if (c % 10 == 3) chk("loop_step", 32'(step_idx), 32'(((c - 3) / 10) % 2));
            if (done) dones++;
            advance_cycle();
        end
        chk("loop_no_done", 32'(dones), 32'd0);
        for (int w = 0; w < 12 && !note_en; w++) advance_cycle();
        chk("loop_note_on", 32'(note_en), 32'd1);
        play_stop = 1'b1;
        advance_cycle();
        play_stop = 1'b0;
        loop_en   = 1'b0;
        #1;
        chk("stop_note_en", 32'(note_en), 32'd0);
        chk("stop_busy",    32'(busy),    32'd0);
        advance_cycle();

        // Arbitration: request arrives in RD, granted in WAIT.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd3, 1'b0, 4'd0, 4'd0);
        advance_cycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 4'd5, 4'd9);
        #1;
        chk("rd_rec_ack",  32'(rec_ack),  32'd0);
        chk("rd_mem_we",   32'(mem_we),   32'd0);
        chk("rd_mem_addr", 32'(mem_addr), 32'd0);
        advance_cycle();
        #1;
        chk("wait_rec_ack",   32'(rec_ack),   32'd1);
        chk("wait_mem_we",    32'(mem_we),    32'd1);
        chk("wait_mem_addr",  32'(mem_addr),  32'd5);
        chk("wait_mem_wdata", 32'(mem_wdata), 32'd9);
        advance_cycle();
        rec_req = 1'b0;
        #1;
        chk("arb_note_bin", 32'(note_bin), 32'd3);
        chk("arb_note_en",  32'(note_en),  32'd1);
        // Overwrite the playing address: current note must not change.
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 4'd0, 4'd5);
        advance_cycle();
        rec_req = 1'b0;
        #1;
        chk("hazard_hold", 32'(note_bin), 32'd3);
        play_stop = 1'b1;
        advance_cycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 4'd0, 4'd0);
        advance_cycle();
        play_start = 1'b0;
        advance_cycle();
        advance_cycle();
        #1;
        chk("hazard_reread", 32'(note_bin), 32'd5);
        play_stop = 1'b1;
        advance_cycle();
        play_stop = 1'b0;

        // len=0 is ignored.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0);
        advance_cycle();
        play_start = 1'b0;
        #1;
        chk("len0_busy", 32'(busy), 32'd0);
        advance_cycle();

        // len=15 clamps to 12 steps.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd15, 1'b0, 4'd0, 4'd0);
        advance_cycle();
        play_start = 1'b0;
        n = 1;
        max_step = 0;
        hit = 1'b0;
        while (n < 200) begin
            #1;
            if (done) begin
                hit = 1'b1;
                break;
            end
            if (int'(step_idx) > max_step) max_step = int'(step_idx);
            advance_cycle();
            n++;
        end
        chk("len15_done_seen", 32'(hit),      32'd1);
        chk("len15_cycles",    32'(n),        32'd121);
        chk("len15_max_step",  32'(max_step), 32'd11);
        advance_cycle();

        // Restart at step 2, then simultaneous start and stop.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd3, 1'b0, 4'd0, 4'd0);
        advance_cycle();
        play_start = 1'b0;
        hit = 1'b0;
        for (int w = 0; w < 40; w++) begin
            #1;
            if (step_idx == 4'd2) begin
                hit = 1'b1;
                break;
            end
            advance_cycle();
        end
        chk("restart_reach_step2", 32'(hit), 32'd1);
        play_start = 1'b1;
        advance_cycle();
        play_start = 1'b0;
        #1;
        chk("restart_busy",     32'(busy),     32'd1);
        chk("restart_step",     32'(step_idx), 32'd0);
        chk("restart_mem_addr", 32'(mem_addr), 32'd0);
        chk("restart_note_en",  32'(note_en),  32'd0);
        for (int c = 0; c < 4; c++) advance_cycle();
        play_start = 1'b1;
        play_stop  = 1'b1;
        advance_cycle();
        play_start = 1'b0;
        play_stop  = 1'b0;
        #1;
        chk("both_busy", 32'(busy), 32'd0);
        chk("both_done", 32'(done), 32'd0);
        advance_cycle();

        // Asynchronous reset in the middle of step 1's note.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd3, 1'b0, 4'd0, 4'd0);
        advance_cycle();
        play_start = 1'b0;
        for (int c = 0; c < 12; c++) advance_cycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 4'd4, 4'd2);
        #1;
        chk("pre_rst_note_en", 32'(note_en),  32'd1);
        chk("pre_rst_step",    32'(step_idx), 32'd1);
        #2;
        RST = 1'b0;
        #1;
        chk("async_note_en", 32'(note_en),  32'd0);
        chk("async_busy",    32'(busy),     32'd0);
        chk("async_step",    32'(step_idx), 32'd0);
        chk("async_mem_we",  32'(mem_we),   32'd0);
        chk("async_rec_ack", 32'(rec_ack),  32'd0);
        model_reset();
        advance_cycle();
        RST = 1'b1;
        rec_req = 1'b0;
        for (int c = 0; c < 5; c++) advance_cycle();
        #1;
        chk("post_rst_idle", 32'(busy), 32'd0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            logic s;
            logic p;
            logic lp;
            s  = ($urandom_range(0, 59) == 0);
            p  = ($urandom_range(0, 199) == 0);
            lp = loop_en;
            if ($urandom_range(0, 99) == 0) lp = ~lp;
            applyStimulus(s, p, lp, 4'($urandom_range(0, 15)),
                          ($urandom_range(0, 4) == 0),
                          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            advance_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
